// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_pkg                                                          |
// | Purpose: Shared constants for the uart_xcvr transceiver: line idle level,  |
// |          TX/RX FSM state encodings and a parameter legality check.         |
// | Ports  : none (package)                                                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  // Transmit FSM states
  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  // Receive FSM states; RX_BREAK holds off until the line returns high
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;
  localparam logic [2:0] RX_BREAK  = 3'd5;

  function automatic bit uart_params_legal(input int clk_div, input int data_bits,
                                           input int stop_bits, input int parity_odd);
    return (clk_div >= 4) && (data_bits >= 5) && (data_bits <= 9) &&
           (stop_bits >= 1) && (stop_bits <= 2) &&
           (parity_odd >= 0) && (parity_odd <= 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_bit_timer                                                    |
// | Purpose: Bit-period counter. Counts 0..CLK_DIV-1 and wraps; i_load        |
// |          restarts the count at 0.                                          |
// | Ports  : clk, rst_n (async active-low), i_load                             |
// |          o_half - high in the cycle the count reaches CLK_DIV/2-1          |
// |          o_full - high in the last cycle of a CLK_DIV-cycle period         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_bit_timer #(
  parameter int CLK_DIV = 234
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_half,
  output logic o_full
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_full) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_half = (r_cnt == C_HALF);
  assign o_full = (r_cnt == C_FULL);

endmodule
`default_nettype wire

// File: rtl/uart_xcvr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_xcvr                                                         |
// | Purpose: Full-duplex UART transceiver, valid/ready byte interfaces.        |
// |          Optional parity enabled by defining UART_XCVR_PARITY_EN.          |
// | Ports  : clk, rst_n (async active-low)                                     |
// |          uart_rx / uart_tx          serial pins (idle high)                |
// |          tx_data/tx_valid/tx_ready  transmit byte handshake                |
// |          rx_data/rx_valid/rx_ready  receive byte handshake                 |
// |          rx_frame_err, rx_parity_err, rx_overrun  1-cycle error pulses     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 234,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  generate
    if (!uart_params_legal(CLK_DIV, DATA_BITS, STOP_BITS, PARITY_ODD)) begin : g_bad_params
      $error("uart_xcvr: illegal CLK_DIV=%0d DATA_BITS=%0d STOP_BITS=%0d PARITY_ODD=%0d",
             CLK_DIV, DATA_BITS, STOP_BITS, PARITY_ODD);
    end
  endgenerate

  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] C_LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] C_LAST_STOP = IDX_W'(STOP_BITS - 1);

`ifdef UART_XCVR_PARITY_EN
  localparam logic       C_ODD           = (PARITY_ODD != 0);
  localparam logic [2:0] C_TX_AFTER_DATA = TX_PARITY;
  localparam logic [2:0] C_RX_AFTER_DATA = RX_PARITY;
`else
  localparam logic [2:0] C_TX_AFTER_DATA = TX_STOP;
  localparam logic [2:0] C_RX_AFTER_DATA = RX_STOP;
`endif

  // ------------------------------------------------------------------ TX
  logic [2:0]           r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [IDX_W-1:0]     r_tx_idx;
  logic                 r_tx_line;
  logic                 w_tx_bit;
  logic                 w_tx_load;
  logic                 w_tx_full;
  logic                 w_tx_unused_half;
`ifdef UART_XCVR_PARITY_EN
  logic                 r_tx_par;
`endif

  assign tx_ready  = (r_tx_state == TX_IDLE);
  assign w_tx_load = tx_ready & tx_valid;
  assign uart_tx   = r_tx_line;

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_tx_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tx_load),
    .o_half (w_tx_unused_half),
    .o_full (w_tx_full)
  );

  // Line level for the current state; registered below, so the pin lags the
  // state by one cycle and each state still lasts exactly CLK_DIV cycles.
  always_comb begin
    w_tx_bit = IDLE_LEVEL;
    case (r_tx_state)
      TX_START:  w_tx_bit = 1'b0;
      TX_DATA:   w_tx_bit = r_tx_shift[0];
`ifdef UART_XCVR_PARITY_EN
      TX_PARITY: w_tx_bit = r_tx_par;
`endif
      default:   w_tx_bit = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_line  <= IDLE_LEVEL;
`ifdef UART_XCVR_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_line <= w_tx_bit;
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            r_tx_shift <= tx_data;
            r_tx_idx   <= '0;
            r_tx_state <= TX_START;
`ifdef UART_XCVR_PARITY_EN
            r_tx_par   <= (^tx_data) ^ C_ODD;
`endif
          end
        end
        TX_START: if (w_tx_full) r_tx_state <= TX_DATA;
        TX_DATA: begin
          if (w_tx_full) begin
            r_tx_shift <= r_tx_shift >> 1;
            if (r_tx_idx == C_LAST_BIT) begin
              r_tx_idx   <= '0;
              r_tx_state <= C_TX_AFTER_DATA;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
            end
          end
        end
        TX_PARITY: if (w_tx_full) r_tx_state <= TX_STOP;
        TX_STOP: begin
          // r_tx_idx counts stop bits here
          if (w_tx_full) begin
            if (r_tx_idx == C_LAST_STOP) begin
              r_tx_idx   <= '0;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ RX
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic [2:0]           r_rx_state;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [IDX_W-1:0]     r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_rx_fall;
  logic                 w_rx_load;
  logic                 w_rx_half;
  logic                 w_rx_full;
  logic                 w_rx_bad_par;
`ifdef UART_XCVR_PARITY_EN
  logic                 r_rx_perr;
  logic                 r_parity_err;
  assign w_rx_bad_par  = r_rx_perr;
  assign rx_parity_err = r_parity_err;
`else
  assign w_rx_bad_par  = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;

  // Sync flops and the previous-bit register all reset to idle-high, so a line
  // already low at reset release appears as a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
      r_prev  <= IDLE_LEVEL;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rx_fall = r_prev & ~r_sync2;
  // Restart on the edge, then again at the start-bit midpoint so every later
  // full tick lands mid-bit.
  assign w_rx_load = ((r_rx_state == RX_IDLE)  & w_rx_fall) |
                     ((r_rx_state == RX_START) & w_rx_half);

  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_rx_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_rx_load),
    .o_half (w_rx_half),
    .o_full (w_rx_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_rx_shift  <= '0;
      r_rx_idx    <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
      r_rx_perr    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // Consumption clear; a delivery later in this block overrides it.
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      case (r_rx_state)
        RX_IDLE: if (w_rx_fall) r_rx_state <= RX_START;
        RX_START: begin
          if (w_rx_half) begin
            if (!r_sync2) begin
              r_rx_idx   <= '0;
              r_rx_state <= RX_DATA;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_full) begin
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_idx == C_LAST_BIT) begin
              r_rx_idx   <= '0;
              r_rx_state <= C_RX_AFTER_DATA;
            end else begin
              r_rx_idx <= r_rx_idx + 1'b1;
            end
          end
        end
`ifdef UART_XCVR_PARITY_EN
        RX_PARITY: begin
          if (w_rx_full) begin
            r_rx_perr  <= r_sync2 ^ (^r_rx_shift) ^ C_ODD;
            r_rx_state <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (w_rx_full) begin
            if (r_sync2) begin
              // Back to IDLE half a bit early to resync on the next start edge
              r_rx_state <= RX_IDLE;
              if (w_rx_bad_par) begin
`ifdef UART_XCVR_PARITY_EN
                r_parity_err <= 1'b1;
`endif
              end else if (!r_rx_valid || rx_ready) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= RX_BREAK;
            end
          end
        end
        RX_BREAK: if (r_sync2) r_rx_state <= RX_IDLE;
        default:  r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_xcvr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_xcvr                                                      |
// | Purpose: Directed self-checking bench for uart_xcvr (CLK_DIV=16, 8 bits). |
// |          Parity/2-stop-bit cases run when UART_XCVR_PARITY_EN is defined.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_uart_xcvr;

  localparam int DIV = 16;
  localparam int DB  = 8;
`ifdef UART_XCVR_PARITY_EN
  localparam int TB_PAR  = 1;
  localparam int TB_STOP = 2;
  localparam int TB_ODD  = 1;
`else
  localparam int TB_PAR  = 0;
  localparam int TB_STOP = 1;
  localparam int TB_ODD  = 0;
`endif
  localparam int NB = 1 + DB + TB_PAR + TB_STOP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_drv = 1'b1;
  logic          r_loop = 1'b0;
  logic          w_rx_line;
  logic          uart_tx;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          rx_overrun;

  int n_vec = 0;
  int n_err = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovr = 0;
  int b_f, b_p, b_o;
  string msg = "Lushay Labs ";

  always #5 clk = ~clk;

  assign w_rx_line = r_loop ? uart_tx : rx_drv;

  uart_xcvr #(
    .CLK_DIV    (DIV),
    .DATA_BITS  (DB),
    .STOP_BITS  (TB_STOP),
    .PARITY_ODD (TB_ODD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (w_rx_line),
    .uart_tx       (uart_tx),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun)
  );

  // Error pulse counters
  always @(posedge clk) begin
    if (rst_n) begin
      n_ferr <= n_ferr + int'(rx_frame_err);
      n_perr <= n_perr + int'(rx_parity_err);
      n_ovr  <= n_ovr + int'(rx_overrun);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame bit k: 0=start, 1..DB data LSB first, then parity, then stop bits
  function automatic logic exp_bit(input logic [DB-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    if (TB_PAR == 1 && k == DB + 1) return (^d) ^ (TB_ODD != 0);
    return 1'b1;
  endfunction

  // Requires tx_ready=1 at call; checks first and last cycle of every bit.
  task automatic tx_check(input logic [DB-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready drop", 32'(tx_ready), 32'd0);
    check("tx idle before start", 32'(uart_tx), 32'd1);
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      check($sformatf("tx bit%0d first", k), 32'(uart_tx), 32'(exp_bit(d, k)));
      tick(DIV - 1);
      check($sformatf("tx bit%0d last", k), 32'(uart_tx), 32'(exp_bit(d, k)));
      check($sformatf("tx_ready bit%0d", k), 32'(tx_ready), 32'(k == NB - 1));
      tick(1);
    end
  endtask

  // Drives one frame on rx_drv; only the first stop bit uses stop_v.
  task automatic drive_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_flip);
    rx_drv = 1'b0;
    tick(DIV);
    for (int i = 0; i < DB; i++) begin
      rx_drv = d[i];
      tick(DIV);
    end
    if (TB_PAR == 1) begin
      rx_drv = (^d) ^ (TB_ODD != 0) ^ par_flip;
      tick(DIV);
    end
    rx_drv = stop_v;
    tick(DIV);
  endtask

  initial begin
    // ---------------- reset state
    tick(3);
    check("reset uart_tx", 32'(uart_tx), 32'd1);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset frame_err", 32'(rx_frame_err), 32'd0);
    check("reset parity_err", 32'(rx_parity_err), 32'd0);
    check("reset overrun", 32'(rx_overrun), 32'd0);
    rst_n = 1'b1;
    tick(4);

    // ---------------- 1: single TX frame of 0x4C
    tx_check(8'h4C);

    // ---------------- 2: loopback stream
    r_loop   = 1'b1;
    rx_ready = 1'b1;
    b_f = n_ferr; b_p = n_perr; b_o = n_ovr;
    fork
      begin : sender
        for (int i = 0; i < 12; i++) begin
          int w;
          tx_data  = msg[i];
          tx_valid = 1'b1;
          w = 0;
          while (!tx_ready && w < 400) begin
            @(negedge clk);
            w++;
          end
          if (w >= 400) check("stream tx_ready timeout", 32'd0, 32'd1);
          @(negedge clk);
          tx_valid = 1'b0;
        end
      end
      begin : collector
        for (int i = 0; i < 12; i++) begin
          int w;
          w = 0;
          while (!rx_valid && w < 600) begin
            @(negedge clk);
            w++;
          end
          if (w >= 600) check("stream rx_valid timeout", 32'd0, 32'd1);
          check($sformatf("stream byte%0d", i), 32'(rx_data), 32'(msg[i]));
          tick(1);
        end
      end
    join
    tick(2 * DIV * NB);
    check("stream frame errs", 32'(n_ferr - b_f), 32'd0);
    check("stream parity errs", 32'(n_perr - b_p), 32'd0);
    check("stream overruns", 32'(n_ovr - b_o), 32'd0);
    check("stream rx_valid idle", 32'(rx_valid), 32'd0);
    r_loop   = 1'b0;
    rx_drv   = 1'b1;
    rx_ready = 1'b0;
    tick(DIV);

    // ---------------- 3: overrun
    b_o = n_ovr;
    drive_frame(8'h3C, 1'b1, 1'b0);
    rx_drv = 1'b1;
    tick(DIV);
    check("ovr first valid", 32'(rx_valid), 32'd1);
    check("ovr first data", 32'(rx_data), 32'h3C);
    drive_frame(8'hC3, 1'b1, 1'b0);
    rx_drv = 1'b1;
    tick(DIV);
    check("ovr pulses", 32'(n_ovr - b_o), 32'd1);
    check("ovr valid held", 32'(rx_valid), 32'd1);
    check("ovr data held", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ovr consumed", 32'(rx_valid), 32'd0);

    // ---------------- 4: framing error and break hold-off
    b_f = n_ferr;
    drive_frame(8'hA5, 1'b0, 1'b0);
    tick(3 * DIV);
    check("frame err pulse", 32'(n_ferr - b_f), 32'd1);
    check("frame no valid", 32'(rx_valid), 32'd0);
    rx_drv = 1'b1;
    tick(DIV);
    drive_frame(8'h5A, 1'b1, 1'b0);
    rx_drv = 1'b1;
    tick(4);
    check("after break valid", 32'(rx_valid), 32'd1);
    check("after break data", 32'(rx_data), 32'h5A);
    check("after break frame errs", 32'(n_ferr - b_f), 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;

    // ---------------- 5: false start, then reset mid TX frame
    b_f = n_ferr;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(NB * DIV + DIV);
    check("glitch no valid", 32'(rx_valid), 32'd0);
    check("glitch no frame err", 32'(n_ferr - b_f), 32'd0);

    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(40);
    check("mid frame line low", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset uart_tx", 32'(uart_tx), 32'd1);
    check("async reset tx_ready", 32'(tx_ready), 32'd1);
    tick(2);
    rst_n = 1'b1;
    tick(3 * DIV);
    check("post reset uart_tx", 32'(uart_tx), 32'd1);
    check("post reset tx_ready", 32'(tx_ready), 32'd1);
    check("post reset rx_valid", 32'(rx_valid), 32'd0);

`ifdef UART_XCVR_PARITY_EN
    // ---------------- 6: odd parity, two stop bits
    tx_check(8'h03);
    b_f = n_ferr; b_p = n_perr;
    drive_frame(8'h55, 1'b1, 1'b1);
    rx_drv = 1'b1;
    tick(DIV);
    check("parity err pulse", 32'(n_perr - b_p), 32'd1);
    check("parity no valid", 32'(rx_valid), 32'd0);
    check("parity no frame err", 32'(n_ferr - b_f), 32'd0);
    drive_frame(8'h55, 1'b0, 1'b1);
    tick(DIV);
    rx_drv = 1'b1;
    tick(DIV);
    check("both bad frame err", 32'(n_ferr - b_f), 32'd1);
    check("both bad parity quiet", 32'(n_perr - b_p), 32'd1);
    drive_frame(8'h96, 1'b1, 1'b0);
    rx_drv = 1'b1;
    tick(4);
    check("good parity valid", 32'(rx_valid), 32'd1);
    check("good parity data", 32'(rx_data), 32'h96);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
